// File: rtl/regfile_2r1w_sb_if.sv
// Port bundle for regfile_2r1w_sb: write, two read ports, reservation and status.
// master drives requests (issue/writeback side); slave is the register file.
interface regfile_2r1w_sb_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic              rbusy_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;
  logic              rbusy_b;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W:0]   busy_cnt;
  logic              rsv_err;

  modport master (
    output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, rsv_en, rsv_addr,
    input  rdata_a, rbusy_a, rdata_b, rbusy_b, busy_cnt, rsv_err
  );

  modport slave (
    input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b, rsv_en, rsv_addr,
    output rdata_a, rbusy_a, rdata_b, rbusy_b, busy_cnt, rsv_err
  );
endinterface

// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write register file with write-first registered reads and a busy scoreboard.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_2r1w_sb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  regfile_2r1w_sb_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef REGFILE_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  busy_nxt_s;
  logic [ADDR_W:0]   busy_cnt_r;
  logic [ADDR_W:0]   busy_cnt_nxt_s;
  logic              rsv_err_r;
  logic              rsv_err_nxt_s;
  logic [WIDTH-1:0]  rdata_a_r, rdata_a_nxt_s;
  logic [WIDTH-1:0]  rdata_b_r, rdata_b_nxt_s;
  logic              rbusy_a_r, rbusy_a_nxt_s;
  logic              rbusy_b_r, rbusy_b_nxt_s;
  logic              rs_in_s, rs_ok_s, wa_ok_s, ra_ok_s, rb_ok_s;
  logic              wr_ok_s, rsv_ok_s, same_s, inc_s, dec_s;

  // Address qualification: in range and, when enabled, not the hardwired zero register.
  always_comb begin
    rs_in_s  = ({1'b0, bus.rsv_addr} < DEPTH_L);
    rs_ok_s  = rs_in_s && !(ZERO_REG && (bus.rsv_addr == {ADDR_W{1'b0}}));
    wa_ok_s  = ({1'b0, bus.waddr} < DEPTH_L) && !(ZERO_REG && (bus.waddr == {ADDR_W{1'b0}}));
    ra_ok_s  = ({1'b0, bus.raddr_a} < DEPTH_L) && !(ZERO_REG && (bus.raddr_a == {ADDR_W{1'b0}}));
    rb_ok_s  = ({1'b0, bus.raddr_b} < DEPTH_L) && !(ZERO_REG && (bus.raddr_b == {ADDR_W{1'b0}}));
    wr_ok_s  = bus.we && wa_ok_s;
    rsv_ok_s = bus.rsv_en && rs_ok_s;
    same_s   = (bus.waddr == bus.rsv_addr);
  end

  // Scoreboard next state: write clears, then reserve sets so a new producer wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (wr_ok_s) begin
      busy_nxt_s[bus.waddr] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (rsv_ok_s) begin
      busy_nxt_s[bus.rsv_addr] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end

    inc_s = rsv_ok_s && !busy_r[bus.rsv_addr];
    dec_s = wr_ok_s && busy_r[bus.waddr] && !(rsv_ok_s && same_s);
    if (inc_s && !dec_s) begin
      busy_cnt_nxt_s = busy_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
    end else if (dec_s && !inc_s) begin
      busy_cnt_nxt_s = busy_cnt_r - {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      busy_cnt_nxt_s = busy_cnt_r;
    end

    // A re-reserve is only legal when the same edge retires the previous producer.
    rsv_err_nxt_s = rsv_err_r
                  | (bus.rsv_en && !rs_in_s)
                  | (rsv_ok_s && busy_r[bus.rsv_addr] && !(wr_ok_s && same_s));
  end

  // Read ports: write-first bypass, out-of-range or zero register reads as 0/not-busy.
  always_comb begin
    rdata_a_nxt_s = rdata_a_r;
    rbusy_a_nxt_s = rbusy_a_r;
    if (!bus.re_a) begin
      rdata_a_nxt_s = rdata_a_r;
    end else if (!ra_ok_s) begin
      rdata_a_nxt_s = {WIDTH{1'b0}};
      rbusy_a_nxt_s = 1'b0;
    end else if (wr_ok_s && (bus.waddr == bus.raddr_a)) begin
      rdata_a_nxt_s = bus.wdata;
      rbusy_a_nxt_s = busy_nxt_s[bus.raddr_a];
    end else begin
      rdata_a_nxt_s = mem_r[bus.raddr_a];
      rbusy_a_nxt_s = busy_nxt_s[bus.raddr_a];
    end

    rdata_b_nxt_s = rdata_b_r;
    rbusy_b_nxt_s = rbusy_b_r;
    if (!bus.re_b) begin
      rdata_b_nxt_s = rdata_b_r;
    end else if (!rb_ok_s) begin
      rdata_b_nxt_s = {WIDTH{1'b0}};
      rbusy_b_nxt_s = 1'b0;
    end else if (wr_ok_s && (bus.waddr == bus.raddr_b)) begin
      rdata_b_nxt_s = bus.wdata;
      rbusy_b_nxt_s = busy_nxt_s[bus.raddr_b];
    end else begin
      rdata_b_nxt_s = mem_r[bus.raddr_b];
      rbusy_b_nxt_s = busy_nxt_s[bus.raddr_b];
    end
  end

  // State and output registers; reset discards data and all pending reservations.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      busy_r     <= {DEPTH{1'b0}};
      busy_cnt_r <= {(ADDR_W+1){1'b0}};
      rsv_err_r  <= 1'b0;
      rdata_a_r  <= {WIDTH{1'b0}};
      rdata_b_r  <= {WIDTH{1'b0}};
      rbusy_a_r  <= 1'b0;
      rbusy_b_r  <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        mem_r[bus.waddr] <= bus.wdata;
      end
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= busy_cnt_nxt_s;
      rsv_err_r  <= rsv_err_nxt_s;
      rdata_a_r  <= rdata_a_nxt_s;
      rdata_b_r  <= rdata_b_nxt_s;
      rbusy_a_r  <= rbusy_a_nxt_s;
      rbusy_b_r  <= rbusy_b_nxt_s;
    end
  end

  assign bus.rdata_a  = rdata_a_r;
  assign bus.rbusy_a  = rbusy_a_r;
  assign bus.rdata_b  = rdata_b_r;
  assign bus.rbusy_b  = rbusy_b_r;
  assign bus.busy_cnt = busy_cnt_r;
  assign bus.rsv_err  = rsv_err_r;
endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb: directed literal checks plus random traffic vs a behavioural model.
// With REGFILE_ZERO_REG_EN defined, runs at DEPTH=24 to cover zero-register and out-of-range cases.
module tb_regfile_2r1w_sb;
`ifdef REGFILE_ZERO_REG_EN
  localparam int DEPTH = 24;
  localparam bit ZR    = 1'b1;
`else
  localparam int DEPTH = 32;
  localparam bit ZR    = 1'b0;
`endif
  localparam int WIDTH  = 32;
  localparam int ADDR_W = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_2r1w_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  regfile_2r1w_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [WIDTH-1:0] mm [DEPTH];
  bit               mb [DEPTH];
  bit               merr;
  logic [WIDTH-1:0] e_rda, e_rdb;
  bit               e_rba, e_rbb;
  int               e_cnt;
  int               checks = 0;
  int               errors = 0;
  bit               chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mrd(input int a);
    if (a >= DEPTH) return {WIDTH{1'b0}};
    else return mm[a];
  endfunction

  function automatic bit mrb(input int a);
    if (a >= DEPTH) return 1'b0;
    else return mb[a];
  endfunction

  // Reference: apply write, then reserve, then read from the updated state.
  function automatic void model_step();
    int w, r, ra, rb;
    bit wr_ok, old_b;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mm[i] = {WIDTH{1'b0}};
        mb[i] = 1'b0;
      end
      merr = 1'b0; e_rda = '0; e_rdb = '0; e_rba = 1'b0; e_rbb = 1'b0;
    end else begin
      w  = int'(bus.waddr);
      r  = int'(bus.rsv_addr);
      ra = int'(bus.raddr_a);
      rb = int'(bus.raddr_b);
      old_b = mrb(r);
      wr_ok = bus.we && (w < DEPTH) && !(ZR && w == 0);
      if (wr_ok) begin
        mm[w] = bus.wdata;
        mb[w] = 1'b0;
      end
      if (bus.rsv_en) begin
        if (r >= DEPTH) merr = 1'b1;
        else if (!(ZR && r == 0)) begin
          if (old_b && !(wr_ok && w == r)) merr = 1'b1;
          mb[r] = 1'b1;
        end
      end
      if (bus.re_a) begin e_rda = mrd(ra); e_rba = mrb(ra); end
      if (bus.re_b) begin e_rdb = mrd(rb); e_rbb = mrb(rb); end
    end
    e_cnt = 0;
    foreach (mb[i]) e_cnt += int'(mb[i]);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic clr();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re_a = 1'b0; bus.raddr_a = '0; bus.re_b = 1'b0; bus.raddr_b = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_rdata_a", bus.rdata_a, e_rda);
      chk("cmp_rbusy_a", bus.rbusy_a, e_rba);
      chk("cmp_rdata_b", bus.rdata_b, e_rdb);
      chk("cmp_rbusy_b", bus.rbusy_b, e_rbb);
      chk("cmp_busy_cnt", bus.busy_cnt, e_cnt);
      chk("cmp_rsv_err", bus.rsv_err, merr);
    end
  end

  initial begin
    clr();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk_en = 1'b1;

    bus.re_a = 1'b1; bus.raddr_a = ADDR_W'(5);
    cycle();
    chk("rst_rdata_a", bus.rdata_a, 64'd0);
    chk("rst_rbusy_a", bus.rbusy_a, 64'd0);
    chk("rst_busy_cnt", bus.busy_cnt, 64'd0);
    chk("rst_rsv_err", bus.rsv_err, 64'd0);

    clr();
    bus.we = 1'b1; bus.waddr = ADDR_W'(7); bus.wdata = 32'hDEADBEEF;
    bus.re_a = 1'b1; bus.raddr_a = ADDR_W'(7);
    cycle();
    chk("bypass_a", bus.rdata_a, 64'hDEADBEEF);
    clr();
    bus.re_b = 1'b1; bus.raddr_b = ADDR_W'(7);
    cycle();
    chk("read_b", bus.rdata_b, 64'hDEADBEEF);
    chk("hold_a", bus.rdata_a, 64'hDEADBEEF);

    clr();
    bus.rsv_en = 1'b1; bus.rsv_addr = ADDR_W'(3);
    cycle();
    chk("rsv3_cnt", bus.busy_cnt, 64'd1);
    clr();
    bus.re_a = 1'b1; bus.raddr_a = ADDR_W'(3);
    cycle();
    chk("rsv3_rbusy", bus.rbusy_a, 64'd1);
    clr();
    bus.we = 1'b1; bus.waddr = ADDR_W'(3); bus.wdata = 32'h55;
    bus.re_b = 1'b1; bus.raddr_b = ADDR_W'(3);
    cycle();
    chk("wb3_cnt", bus.busy_cnt, 64'd0);
    chk("wb3_rdata", bus.rdata_b, 64'h55);
    chk("wb3_rbusy", bus.rbusy_b, 64'd0);

    clr();
    bus.rsv_en = 1'b1; bus.rsv_addr = ADDR_W'(9);
    cycle();
    bus.we = 1'b1; bus.waddr = ADDR_W'(9); bus.wdata = 32'h1234;
    bus.re_a = 1'b1; bus.raddr_a = ADDR_W'(9);
    cycle();
    chk("rsvwr9_cnt", bus.busy_cnt, 64'd1);
    chk("rsvwr9_err", bus.rsv_err, 64'd0);
    chk("rsvwr9_rdata", bus.rdata_a, 64'h1234);
    chk("rsvwr9_rbusy", bus.rbusy_a, 64'd1);

    clr();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.rsv_en = 1'b1; bus.rsv_addr = ADDR_W'(4);
    cycle();
    cycle();
    chk("dbl_err", bus.rsv_err, 64'd1);
    chk("dbl_cnt", bus.busy_cnt, 64'd1);
    clr();
    cycle(); cycle(); cycle();
    chk("dbl_sticky", bus.rsv_err, 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("dbl_clr_err", bus.rsv_err, 64'd0);
    chk("dbl_clr_cnt", bus.busy_cnt, 64'd0);

    clr();
    bus.we = 1'b1; bus.waddr = ADDR_W'(0); bus.wdata = 32'hFFFF;
    cycle();
    clr();
    bus.re_a = 1'b1; bus.raddr_a = ADDR_W'(0);
    cycle();
`ifdef REGFILE_ZERO_REG_EN
    chk("zr_rdata", bus.rdata_a, 64'd0);
    chk("zr_rbusy", bus.rbusy_a, 64'd0);
    clr();
    bus.rsv_en = 1'b1; bus.rsv_addr = ADDR_W'(0);
    cycle();
    chk("zr_rsv_cnt", bus.busy_cnt, 64'd0);
    chk("zr_rsv_err", bus.rsv_err, 64'd0);
    clr();
    bus.we = 1'b1; bus.waddr = ADDR_W'(5); bus.wdata = 32'hA5A5;
    bus.re_b = 1'b1; bus.raddr_b = ADDR_W'(5);
    cycle();
    chk("oor_pre", bus.rdata_b, 64'hA5A5);
    clr();
    bus.re_b = 1'b1; bus.raddr_b = ADDR_W'(30);
    cycle();
    chk("oor_rdata", bus.rdata_b, 64'd0);
    clr();
    bus.rsv_en = 1'b1; bus.rsv_addr = ADDR_W'(30);
    cycle();
    chk("oor_rsv_err", bus.rsv_err, 64'd1);
    chk("oor_rsv_cnt", bus.busy_cnt, 64'd0);
`else
    chk("r0_rdata", bus.rdata_a, 64'hFFFF);
    clr();
    bus.rsv_en = 1'b1; bus.rsv_addr = ADDR_W'(0);
    bus.re_b = 1'b1; bus.raddr_b = ADDR_W'(0);
    cycle();
    chk("r0_rsv_cnt", bus.busy_cnt, 64'd1);
    chk("r0_rbusy", bus.rbusy_b, 64'd1);
`endif

    // Random traffic with occasional resets, addresses biased towards a small set.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      bus.we      = ($urandom_range(0, 1) == 1);
      bus.waddr   = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      bus.wdata   = $urandom;
      bus.re_a    = ($urandom_range(0, 3) != 0);
      bus.raddr_a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      bus.re_b    = ($urandom_range(0, 3) != 0);
      bus.raddr_b = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      bus.rsv_en  = ($urandom_range(0, 2) == 0);
      bus.rsv_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
      cycle();
    end
    rst = 1'b0;
    clr();
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
Parametrised register file for the processor datapath, generalising the flat 32x32 combinational read mux into a storage block.
- Two registered read ports, one write port.
- Per-register busy scoreboard that the issue stage uses to detect pending writebacks.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
WIDTH, 32, data width of each register in bits
DEPTH, 32, number of registers; any value >= 2, need not be a power of two
ADDR_W, $clog2(DEPTH), address width; derived localparam, not overridable

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
re_a  input  1  read enable, port A
raddr_a  input  ADDR_W  read address, port A
rdata_a  output  WIDTH  registered read data, port A
rbusy_a  output  1  registered busy flag for raddr_a
re_b  input  1  read enable, port B
raddr_b  input  ADDR_W  read address, port B
rdata_b  output  WIDTH  registered read data, port B
rbusy_b  output  1  registered busy flag for raddr_b
rsv_en  input  1  reserve request: mark register as pending write
rsv_addr  input  ADDR_W  register to reserve
busy_cnt  output  ADDR_W+1  number of registers currently busy
rsv_err  output  1  sticky error flag

Behaviour:
- Interface: one clock domain, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at edge):
  - all registers cleared to 0; all busy bits 0
  - rdata_a/b = 0, rbusy_a/b = 0, busy_cnt = 0, rsv_err = 0
  - rst overrides every same-cycle we/re/rsv_en
  - reset mid-operation discards all pending reservations
- Write: we=1 at edge -> mem[waddr] <= wdata and busy[waddr] <= 0.
- Read latency: 1 cycle.
  - re_x=1 at edge -> rdata_x <= value at raddr_x after this edge's write (write-first bypass): wdata if we && waddr==raddr_x, else mem[raddr_x].
  - rbusy_x <= busy[raddr_x] as updated at the same edge (post write-clear, post reserve-set).
  - re_x=0 -> rdata_x and rbusy_x hold their previous values.
  - Both ports may read the same address in the same cycle; both return identical data.
- Reserve: rsv_en=1 at edge -> busy[rsv_addr] <= 1.
  - If busy[rsv_addr] was already 1 and no same-edge write clears it: busy stays 1 and rsv_err <= 1.
- Simultaneous write and reserve, same address: data is written, busy ends 1 (the new producer wins), no error. Same-edge read of that address returns wdata with rbusy=1.
- Simultaneous write and reserve, different addresses: both take effect independently.
- busy_cnt:
  - registered population count of busy bits, updated the same edge as the bits; net change is -1, 0 or +1 per cycle
  - range 0..DEPTH, no wrap
- Out-of-range address (>= DEPTH, possible only when DEPTH is not a power of two):
  - write dropped
  - read returns rdata=0, rbusy=0
  - reserve dropped and sets rsv_err
- rsv_err is sticky until rst.

Optional Feature:
Macro REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired zero.
  - writes to address 0 are dropped; reads of 0 return 0 with rbusy=0, including the bypass path
  - reserve of 0 is ignored, sets no error and does not change busy_cnt
- Undefined: register 0 is an ordinary register, identical to all others.

Test Plan:
- Reset then read: rst 1 cycle; re_a=1, raddr_a=5 -> next cycle rdata_a=0, rbusy_a=0, busy_cnt=0, rsv_err=0.
- Write/read and bypass: we=1, waddr=7, wdata=0xDEADBEEF, with re_a=1, raddr_a=7 on the same edge -> rdata_a=0xDEADBEEF one cycle later. The following cycle, re_b=1, raddr_b=7 -> rdata_b=0xDEADBEEF. With re_a=0, rdata_a holds.
- Scoreboard: rsv_en on 3 -> busy_cnt=1. Read 3 -> rbusy=1. we on 3 with wdata=0x55 -> busy_cnt=0; a read on the same edge gives rdata=0x55, rbusy=0.
- Reserve and write same edge: busy[9]=1; rsv_en+we both on 9, wdata=0x1234 -> busy_cnt unchanged at 1, rsv_err=0, same-edge read of 9 gives 0x1234 with rbusy=1.
- Double reserve: rsv_en on 4 for two consecutive cycles with no write -> rsv_err=1 after second edge, busy_cnt=1. rsv_err stays 1 until rst, then 0.
- DEPTH=24, REGFILE_ZERO_REG_EN defined:
  - we to 0 with 0xFFFF then read 0 -> 0, rbusy 0
  - rsv_en on 0 -> busy_cnt stays 0, rsv_err=0
  - read 30 -> 0; rsv_en on 30 -> rsv_err=1
